// File: rtl/up5bit_pwm_gen.sv
// rtl/up5bit_pwm_gen.sv - PWM generator driven by a free-running up counter, double-buffered duty
module up5bit_pwm_gen #(
  parameter int WIDTH        = 5,
  parameter int PERIOD_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        count,
  input  logic [WIDTH:0]          duty_in,
  input  logic                    duty_valid,
  output logic                    duty_ready,
  output logic                    pwm_out,
  output logic                    wrap,
  output logic [PERIOD_CNT_W-1:0] period_cnt,
  output logic [WIDTH:0]          active_duty,
  output logic                    seq_err
);

  localparam logic [WIDTH:0]   DUTY_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH:0]          pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic                    duty_ready_q, duty_ready_d;
  logic [WIDTH:0]          active_duty_q, active_duty_d;
  logic                    pwm_out_q, pwm_out_d;
  logic                    wrap_q, wrap_d;
  logic [PERIOD_CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    seq_err_q, seq_err_d;

  logic                    boundary;
  logic                    load;
  logic                    xfer;
  logic [WIDTH:0]          duty_clamped;
  logic [WIDTH:0]          eff_duty;
  logic [WIDTH-1:0]        prev_inc;

  // Next-state logic: sync/FSM, handshake, boundary load, compare, wrap and sequence check
  always_comb begin
    boundary     = (count == CNT_ZERO);
    load         = boundary && pending_valid_q;
    xfer         = duty_valid && duty_ready_q;
    duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    eff_duty     = load ? pending_q : active_duty_q;
    prev_inc     = prev_q + WIDTH'(1);

    state_d = state_q;
    if (state_q == WAIT_SYNC && boundary) begin
      state_d = RUN;
    end

    // A pending value can only exist while ready is low, so load and
    // transfer never coincide; a transfer in a boundary cycle waits a period.
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    active_duty_d   = active_duty_q;
    if (load) begin
      active_duty_d   = pending_q;
      pending_valid_d = 1'b0;
    end else if (xfer) begin
      pending_d       = duty_clamped;
      pending_valid_d = 1'b1;
    end
    duty_ready_d = !pending_valid_d;

    pwm_out_d = (state_d == RUN) && ({1'b0, count} < eff_duty);

    wrap_d       = prev_valid_q && (prev_q == CNT_MAX) && boundary;
    period_cnt_d = period_cnt_q + (wrap_d ? PERIOD_CNT_W'(1) : PERIOD_CNT_W'(0));

    prev_d       = count;
    prev_valid_d = 1'b1;
    seq_err_d    = seq_err_q | (prev_valid_q && (count != prev_inc) && !boundary);
  end

  // State registers with synchronous reset; reset also discards any pending duty
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= WAIT_SYNC;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      duty_ready_q    <= 1'b1;
      active_duty_q   <= '0;
      pwm_out_q       <= 1'b0;
      wrap_q          <= 1'b0;
      period_cnt_q    <= '0;
      prev_q          <= '0;
      prev_valid_q    <= 1'b0;
      seq_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      duty_ready_q    <= duty_ready_d;
      active_duty_q   <= active_duty_d;
      pwm_out_q       <= pwm_out_d;
      wrap_q          <= wrap_d;
      period_cnt_q    <= period_cnt_d;
      prev_q          <= prev_d;
      prev_valid_q    <= prev_valid_d;
      seq_err_q       <= seq_err_d;
    end
  end

  assign duty_ready  = duty_ready_q;
  assign pwm_out     = pwm_out_q;
  assign wrap        = wrap_q;
  assign period_cnt  = period_cnt_q;
  assign active_duty = active_duty_q;
  assign seq_err     = seq_err_q;

endmodule
